fx_bus_arb: RTL and testbench



---
 rtl/fx_bus_arb_if.sv | 40 ++++
 rtl/fx_bus_arb.sv | 141 ++++++++++++++
 tb/tb_fx_bus_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fx_bus_arb_if.sv
// fx register bus bundle: two requesting masters plus the shared fx slave bus.
// The master modport is the arbiter's view. The slave modport is the surrounding environment.
interface fx_bus_arb_if;
  logic        m0_req;
  logic        m0_wr;
  logic [21:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_ack;
  logic [7:0]  m0_rdata;

  logic        m1_req;
  logic        m1_wr;
  logic [21:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_ack;
  logic [7:0]  m1_rdata;

  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  fx_q,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr
  );

  modport slave (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output fx_q,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr
  );
endinterface

// File: rtl/fx_bus_arb.sv
// Two-master round-robin arbiter and single-byte transaction sequencer for the fx register bus.
// All outputs come straight from registers; master inputs only matter in the idle state.
module fx_bus_arb #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  fx_bus_arb_if.master     bus,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRwait, StCap, StDone} state_e;

  localparam logic [1:0] WaitInit = 2'(RD_LAT - 1);

  state_e             state_q;
  logic               gnt_q;
  logic               last_gnt_q;
  logic [21:0]        cmd_addr_q;
  logic [7:0]         cmd_wdata_q;
  logic [1:0]         wait_q;
  logic               fx_wr_q;
  logic               fx_rd_q;
  logic               m0_ack_q;
  logic               m1_ack_q;
  logic [7:0]         m0_rdata_q;
  logic [7:0]         m1_rdata_q;
  logic               busy_q;
  logic [CNT_W-1:0]   txn_cnt_q;

  logic               sel_gnt;
  logic               sel_wr;
  logic [21:0]        sel_addr;
  logic [7:0]         sel_wdata;

  // Contention goes to the master that did not win last time; a lone requester always wins.
  always_comb begin
    sel_gnt = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      sel_gnt = ~last_gnt_q;
    end else if (bus.m1_req) begin
      sel_gnt = 1'b1;
    end
    sel_wr    = sel_gnt ? bus.m1_wr    : bus.m0_wr;
    sel_addr  = sel_gnt ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel_gnt ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      wait_q      <= '0;
      fx_wr_q     <= 1'b0;
      fx_rd_q     <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy_q      <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      fx_wr_q  <= 1'b0;
      fx_rd_q  <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.m0_req || bus.m1_req) begin
            gnt_q       <= sel_gnt;
            last_gnt_q  <= sel_gnt;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            busy_q      <= 1'b1;
            if (sel_wr) begin
              fx_wr_q <= 1'b1;
              state_q <= StWr;
            end else begin
              fx_rd_q <= 1'b1;
              state_q <= StRd;
            end
          end
        end
        StWr: begin
          m0_ack_q <= ~gnt_q;
          m1_ack_q <= gnt_q;
          state_q  <= StDone;
        end
        StRd: begin
          if (RD_LAT > 1) begin
            wait_q  <= WaitInit;
            state_q <= StRwait;
          end else begin
            state_q <= StCap;
          end
        end
        StRwait: begin
          if (wait_q == 2'd1) begin
            state_q <= StCap;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        StCap: begin
          if (gnt_q) begin
            m1_rdata_q <= bus.fx_q;
          end else begin
            m0_rdata_q <= bus.fx_q;
          end
          m0_ack_q <= ~gnt_q;
          m1_ack_q <= gnt_q;
          state_q  <= StDone;
        end
        StDone: begin
          txn_cnt_q <= txn_cnt_q + 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.fx_waddr = cmd_addr_q;
  assign bus.fx_raddr = cmd_addr_q;
  assign bus.fx_data  = cmd_wdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign busy         = busy_q;
  assign txn_cnt      = txn_cnt_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Directed bench for fx_bus_arb: read latency 1 and 3 builds plus a narrow-counter build for wrap.
module tb_fx_bus_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int acks = 0;

  logic [7:0]  sd1;
  logic [7:0]  sd3;
  logic        busy1, busy3, busyc;
  logic [15:0] txn1, txn3;
  logic [3:0]  txnc;
  logic [2:0]  hist1 = '0;
  logic [2:0]  hist3 = '0;

  fx_bus_arb_if bus1 ();
  fx_bus_arb_if bus3 ();
  fx_bus_arb_if busc ();

  fx_bus_arb #(.RD_LAT(1), .CNT_W(16)) dut1 (
    .clk_sys(clk), .rst(rst), .bus(bus1), .busy(busy1), .txn_cnt(txn1)
  );
  fx_bus_arb #(.RD_LAT(3), .CNT_W(16)) dut3 (
    .clk_sys(clk), .rst(rst), .bus(bus3), .busy(busy3), .txn_cnt(txn3)
  );
  fx_bus_arb #(.RD_LAT(1), .CNT_W(4)) dutc (
    .clk_sys(clk), .rst(rst), .bus(busc), .busy(busyc), .txn_cnt(txnc)
  );

  // Slave models return data exactly RD_LAT cycles after the read strobe, zero otherwise.
  always @(posedge clk) begin
    hist1 <= {hist1[1:0], bus1.fx_rd};
    hist3 <= {hist3[1:0], bus3.fx_rd};
  end
  assign bus1.fx_q = hist1[0] ? sd1 : 8'h00;
  assign bus3.fx_q = hist3[2] ? sd3 : 8'h00;
  assign busc.fx_q = 8'h00;

  always @(negedge clk) begin
    if ((bus1.fx_wr && bus1.fx_rd) || (bus3.fx_wr && bus3.fx_rd) || (busc.fx_wr && busc.fx_rd))
      overlap <= overlap + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sd1 = 8'h00;
    sd3 = 8'h00;
    bus1.m0_req = 0; bus1.m0_wr = 0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
    bus1.m1_req = 0; bus1.m1_wr = 0; bus1.m1_addr = '0; bus1.m1_wdata = '0;
    bus3.m0_req = 0; bus3.m0_wr = 0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
    bus3.m1_req = 0; bus3.m1_wr = 0; bus3.m1_addr = '0; bus3.m1_wdata = '0;
    busc.m0_req = 0; busc.m0_wr = 0; busc.m0_addr = '0; busc.m0_wdata = '0;
    busc.m1_req = 0; busc.m1_wr = 0; busc.m1_addr = '0; busc.m1_wdata = '0;
    tick; tick;

    // Start a write, then reset in its strobe cycle for three cycles.
    rst = 1'b0;
    bus1.m0_req = 1; bus1.m0_wr = 1; bus1.m0_addr = 22'h0A0020; bus1.m0_wdata = 8'h11;
    tick;
    check_eq("pre_rst_stb", bus1.fx_wr, 1);
    rst = 1'b1;
    bus1.m0_req = 0;
    tick; tick; tick;
    check_eq("rst_fx_wr", bus1.fx_wr, 0);
    check_eq("rst_fx_rd", bus1.fx_rd, 0);
    check_eq("rst_waddr", bus1.fx_waddr, 0);
    check_eq("rst_data", bus1.fx_data, 0);
    check_eq("rst_ack", {bus1.m1_ack, bus1.m0_ack}, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_txn", txn1, 0);

    // m0 write 0x3A to 0x0A0020.
    rst = 1'b0;
    bus1.m0_req = 1; bus1.m0_wr = 1; bus1.m0_addr = 22'h0A0020; bus1.m0_wdata = 8'h3A;
    tick;
    check_eq("wr_stb", bus1.fx_wr, 1);
    check_eq("wr_addr", bus1.fx_waddr, 32'h0A0020);
    check_eq("wr_data", bus1.fx_data, 32'h3A);
    check_eq("wr_no_rd", bus1.fx_rd, 0);
    check_eq("wr_busy", busy1, 1);
    check_eq("wr_ack_early", bus1.m0_ack, 0);
    tick;
    check_eq("wr_ack", bus1.m0_ack, 1);
    check_eq("wr_other_ack", bus1.m1_ack, 0);
    check_eq("wr_stb_once", bus1.fx_wr, 0);
    bus1.m0_req = 0;
    tick;
    check_eq("wr_ack_once", bus1.m0_ack, 0);
    check_eq("wr_busy_fall", busy1, 0);
    check_eq("wr_txn", txn1, 1);
    check_eq("wr_addr_hold", bus1.fx_waddr, 32'h0A0020);

    // m1 read of 0x0A0011, slave answers 0x5C one cycle after the strobe.
    sd1 = 8'h5C;
    bus1.m1_req = 1; bus1.m1_wr = 0; bus1.m1_addr = 22'h0A0011;
    tick;
    check_eq("rd_stb", bus1.fx_rd, 1);
    check_eq("rd_addr", bus1.fx_raddr, 32'h0A0011);
    check_eq("rd_no_wr", bus1.fx_wr, 0);
    tick;
    check_eq("rd_stb_once", bus1.fx_rd, 0);
    check_eq("rd_ack_early", bus1.m1_ack, 0);
    tick;
    check_eq("rd_ack", bus1.m1_ack, 1);
    check_eq("rd_data", bus1.m1_rdata, 32'h5C);
    check_eq("rd_other_ack", bus1.m0_ack, 0);
    check_eq("rd_other_data", bus1.m0_rdata, 0);
    bus1.m1_req = 0;
    tick;
    check_eq("rd_txn", txn1, 2);
    check_eq("rd_data_hold", bus1.m1_rdata, 32'h5C);

    // Both masters hold requests from reset: grants alternate starting with m0.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus1.m0_req = 1; bus1.m0_wr = 1; bus1.m0_addr = 22'h0A0100; bus1.m0_wdata = 8'h01;
    bus1.m1_req = 1; bus1.m1_wr = 1; bus1.m1_addr = 22'h0A0200; bus1.m1_wdata = 8'h02;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("rr_stb", bus1.fx_wr, 1);
      check_eq("rr_addr", bus1.fx_waddr, (i % 2 == 0) ? 32'h0A0100 : 32'h0A0200);
      tick;
      check_eq("rr_ack0", bus1.m0_ack, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_ack1", bus1.m1_ack, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 3) begin
        bus1.m0_req = 0;
        bus1.m1_req = 0;
      end
      tick;
    end
    check_eq("rr_txn", txn1, 4);
    check_eq("rr_busy", busy1, 0);

    // RD_LAT=3: slave returns 0xA7 three cycles after the strobe.
    sd3 = 8'hA7;
    bus3.m0_req = 1; bus3.m0_wr = 0; bus3.m0_addr = 22'h0B1234;
    tick;
    check_eq("l3_stb", bus3.fx_rd, 1);
    check_eq("l3_addr", bus3.fx_raddr, 32'h0B1234);
    tick;
    check_eq("l3_stb_once", bus3.fx_rd, 0);
    check_eq("l3_busy", busy3, 1);
    tick;
    check_eq("l3_ack_t3", bus3.m0_ack, 0);
    tick;
    check_eq("l3_ack_t4", bus3.m0_ack, 0);
    tick;
    check_eq("l3_ack", bus3.m0_ack, 1);
    check_eq("l3_data", bus3.m0_rdata, 32'hA7);
    bus3.m0_req = 0;
    tick;
    check_eq("l3_txn", txn3, 1);

    // Reset lands in the wait cycle of an m1 read: transaction vanishes.
    sd3 = 8'h99;
    bus3.m1_req = 1; bus3.m1_wr = 0; bus3.m1_addr = 22'h0B0001;
    tick;
    tick;
    check_eq("ab_busy_pre", busy3, 1);
    rst = 1'b1;
    bus3.m1_req = 0;
    tick;
    check_eq("ab_busy", busy3, 0);
    check_eq("ab_txn", txn3, 0);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus3.m1_ack || bus3.m0_ack) acks++;
      tick;
    end
    check_eq("ab_no_ack", acks, 0);
    check_eq("ab_rdata1", bus3.m1_rdata, 0);
    check_eq("ab_rdata0", bus3.m0_rdata, 0);

    // Following m0 read completes normally.
    sd3 = 8'h42;
    bus3.m0_req = 1; bus3.m0_wr = 0; bus3.m0_addr = 22'h0B0002;
    tick; tick; tick; tick;
    check_eq("ar_ack_early", bus3.m0_ack, 0);
    tick;
    check_eq("ar_ack", bus3.m0_ack, 1);
    check_eq("ar_data", bus3.m0_rdata, 32'h42);
    check_eq("ar_other", bus3.m1_rdata, 0);
    bus3.m0_req = 0;
    tick;
    check_eq("ar_txn", txn3, 1);

    // 4-bit counter: fifteen back-to-back writes reach all-ones, the sixteenth wraps to zero.
    busc.m0_req = 1; busc.m0_wr = 1; busc.m0_addr = 22'h000001; busc.m0_wdata = 8'h5A;
    for (int i = 0; i < 45; i++) tick;
    check_eq("wrap_max", txnc, 32'hF);
    tick; tick;
    busc.m0_req = 0;
    tick;
    check_eq("wrap_zero", txnc, 0);
    check_eq("wrap_busy", busyc, 0);

    check_eq("no_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
